// File: rtl/dff_arb_pkg.sv
// Shared definitions for the round-robin write arbiter.
// Holds the arbiter FSM state type and the default requester count and data width.
package dff_arb_pkg;

  localparam int unsigned NUM_REQ_DEF = 4;
  localparam int unsigned WIDTH_DEF   = 8;

  typedef enum logic {
    ARB    = 1'b0,
    LOCKED = 1'b1
  } arb_state_e;

endpackage

// File: rtl/dff_write_arbiter_if.sv
// Client-side bundle of the shared-register write arbiter.
// The master side belongs to the requesters: it drives req, wdata and lock.
// The slave side belongs to the arbiter: it drives gnt, en, d, q and last_id.
// The lock signal exists only when ARB_LOCK_EN is defined.
interface dff_write_arbiter_if #(
  parameter int unsigned NUM_REQ = dff_arb_pkg::NUM_REQ_DEF,
  parameter int unsigned WIDTH   = dff_arb_pkg::WIDTH_DEF
);

  localparam int unsigned IDW = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]       req;
  logic [NUM_REQ*WIDTH-1:0] wdata;
`ifdef ARB_LOCK_EN
  logic [NUM_REQ-1:0]       lock;
`endif
  logic [NUM_REQ-1:0]       gnt;
  logic                     en;
  logic [WIDTH-1:0]         d;
  logic [WIDTH-1:0]         q;
  logic [IDW-1:0]           last_id;

`ifdef ARB_LOCK_EN
  modport master (output req, wdata, lock, input gnt, en, d, q, last_id);
  modport slave  (input req, wdata, lock, output gnt, en, d, q, last_id);
`else
  modport master (output req, wdata, input gnt, en, d, q, last_id);
  modport slave  (input req, wdata, output gnt, en, d, q, last_id);
`endif

endinterface

// File: rtl/dff_write_arbiter_rr_pick.sv
// rr_pick: combinational round-robin selector.
// Scans req starting at ptr and wrapping past NUM_REQ-1 back to 0; the first
// asserted request wins.
// Ports: req (requests), ptr (scan start) -> gnt (one-hot, 0 if none), winner (index).
module rr_pick #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned IDW     = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDW-1:0]     ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IDW-1:0]     winner
);

  logic found;
  int   idx;

  // Priority scan rotated by ptr; ptr is always below NUM_REQ, so the sum
  // needs only a single modulo.
  always_comb begin
    gnt    = '0;
    winner = '0;
    found  = 1'b0;
    idx    = 0;
    for (int k = 0; k < int'(NUM_REQ); k++) begin
      idx = (int'(ptr) + k) % int'(NUM_REQ);
      if (!found && req[idx]) begin
        gnt[idx] = 1'b1;
        winner   = IDW'(idx);
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/dff_write_arbiter.sv
// dff_write_arbiter: round-robin arbiter in front of a shared WIDTH-bit
// enabled register. Each cycle one requester is granted, its data is written
// into the register on the next edge, and its index is kept as last_id.
// Ports: clk, rst (async, active-high), bus (slave side of dff_write_arbiter_if:
//   req/wdata[/lock] in; gnt/en/d combinational out; q/last_id registered out).
// Optional feature macro: ARB_LOCK_EN (ownership hold through the lock input).
module dff_write_arbiter
  import dff_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = NUM_REQ_DEF,
  parameter int unsigned WIDTH   = WIDTH_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  dff_write_arbiter_if.slave   bus
);

  localparam int unsigned IDW = $clog2(NUM_REQ);

  arb_state_e         state;
  logic [IDW-1:0]     ptr;
  logic [IDW-1:0]     last_id;
  logic [WIDTH-1:0]   q;

  logic [NUM_REQ-1:0] rr_gnt;
  logic [IDW-1:0]     rr_win;
  logic [NUM_REQ-1:0] gnt;
  logic [IDW-1:0]     win;
  logic               en;
  logic [WIDTH-1:0]   d;
  logic               hold;
  logic               win_lock;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDW     (IDW)
  ) u_rr_pick (
    .req    (bus.req),
    .ptr    (ptr),
    .gnt    (rr_gnt),
    .winner (rr_win)
  );

  // The lock owner is always the most recent writer, so last_id names it.
`ifdef ARB_LOCK_EN
  assign hold     = bus.req[last_id] & bus.lock[last_id];
  assign win_lock = bus.lock[win];
`else
  assign hold     = 1'b0;
  assign win_lock = 1'b0;
`endif

  // Grant selection: owner keeps the grant while it holds req and lock;
  // otherwise round-robin from ptr, which also covers the release cycle.
  always_comb begin
    gnt = '0;
    win = '0;
    if (!rst) begin
      if (state == LOCKED && hold) begin
        gnt[last_id] = 1'b1;
        win          = last_id;
      end else begin
        gnt = rr_gnt;
        win = rr_win;
      end
    end
  end

  assign en = |gnt;
  assign d  = en ? bus.wdata[int'(win)*int'(WIDTH) +: WIDTH] : '0;

  // Shared storage register plus arbitration state, all updated on the write edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q       <= '0;
      ptr     <= '0;
      last_id <= '0;
      state   <= ARB;
    end else if (en) begin
      q       <= d;
      last_id <= win;
      ptr     <= (win == IDW'(NUM_REQ - 1)) ? '0 : win + IDW'(1);
      state   <= win_lock ? LOCKED : ARB;
    end else begin
      state   <= ARB;
    end
  end

  assign bus.gnt     = gnt;
  assign bus.en      = en;
  assign bus.d       = d;
  assign bus.q       = q;
  assign bus.last_id = last_id;

endmodule

// File: tb/tb_dff_write_arbiter.sv
// Self-checking bench for dff_write_arbiter (NUM_REQ=4, WIDTH=8).
// Directed test-plan scenarios followed by randomized traffic, all compared
// against a behavioural model of the round-robin/lock rules.
module tb_dff_write_arbiter;
  import dff_arb_pkg::*;

  localparam int unsigned N = 4;
  localparam int unsigned W = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  dff_write_arbiter_if #(.NUM_REQ(N), .WIDTH(W)) bus ();

  dff_write_arbiter #(.NUM_REQ(N), .WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Reference state: scan start, register, last writer, lock owner (-1 none).
  int         m_ptr;
  int         m_last;
  int         m_owner;
  logic [7:0] m_q;

  logic [3:0] obs_gnt;
  logic [7:0] obs_q;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_ptr   = 0;
    m_last  = 0;
    m_owner = -1;
    m_q     = 8'h00;
  endfunction

  function automatic int exp_winner(input logic [3:0] rq, input logic [3:0] lk);
    if (m_owner >= 0 && rq[m_owner] && lk[m_owner]) return m_owner;
    for (int k = 0; k < int'(N); k++) begin
      int i;
      i = (m_ptr + k) % int'(N);
      if (rq[i]) return i;
    end
    return -1;
  endfunction

  // One cycle: drive at negedge, check just after, advance model on posedge.
  task automatic step(input logic r, input logic [3:0] rq, input logic [31:0] wd,
                      input logic [3:0] lk);
    int         w;
    logic [3:0] lk_eff;
    logic [7:0] exp_d;
    @(negedge clk);
    rst       = r;
    bus.req   = rq;
    bus.wdata = wd;
`ifdef ARB_LOCK_EN
    bus.lock  = lk;
    lk_eff    = lk;
`else
    lk_eff    = lk & 4'b0000;
`endif
    if (r) model_reset();
    #1;
    w     = r ? -1 : exp_winner(rq, lk_eff);
    exp_d = (w >= 0) ? wd[w*8 +: 8] : 8'h00;
    obs_gnt = bus.gnt;
    obs_q   = bus.q;
    check("gnt",     32'(bus.gnt),     (w >= 0) ? (32'd1 << w) : 32'd0);
    check("en",      32'(bus.en),      (w >= 0) ? 32'd1 : 32'd0);
    check("d",       32'(bus.d),       32'(exp_d));
    check("q",       32'(bus.q),       32'(m_q));
    check("last_id", 32'(bus.last_id), 32'(m_last));
    @(posedge clk);
    if (!r) begin
      if (w >= 0) begin
        m_q     = exp_d;
        m_last  = w;
        m_ptr   = (w + 1) % int'(N);
        m_owner = lk_eff[w] ? w : -1;
      end else begin
        m_owner = -1;
      end
    end
  endtask

  logic [31:0] wd;
  logic [31:0] prev_wd;
  int unsigned fair_tbl [5] = '{1, 2, 4, 8, 1};

  initial begin
    bus.req   = '0;
    bus.wdata = '0;
`ifdef ARB_LOCK_EN
    bus.lock  = '0;
`endif
    model_reset();

    // Reset with all requests asserted
    step(1'b1, 4'b1111, 32'hDEADBEEF, 4'b0000);
    step(1'b1, 4'b1111, 32'hDEADBEEF, 4'b0000);
    check("rst_gnt", 32'(obs_gnt), 32'd0);
    check("rst_q",   32'(obs_q),   32'd0);

    // Single requester
    step(1'b0, 4'b0010, 32'h0000A500, 4'b0000);
    check("single_gnt", 32'(obs_gnt), 32'h2);
    step(1'b0, 4'b0000, 32'h0, 4'b0000);
    check("single_q", 32'(obs_q), 32'hA5);
    step(1'b0, 4'b0000, 32'h0, 4'b0000);
    check("single_hold", 32'(obs_q), 32'hA5);

    // Fairness right after reset
    step(1'b1, 4'b1111, 32'h0, 4'b0000);
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 4'b1111, $urandom(), 4'b0000);
      check("fair_gnt", 32'(obs_gnt), 32'(fair_tbl[i]));
    end

    // Wrap-around past requester 3
    step(1'b0, 4'b0100, $urandom(), 4'b0000);
    check("wrap_g2", 32'(obs_gnt), 32'h4);
    step(1'b0, 4'b0011, $urandom(), 4'b0000);
    check("wrap_g0", 32'(obs_gnt), 32'h1);
    step(1'b0, 4'b0011, $urandom(), 4'b0000);
    check("wrap_g1", 32'(obs_gnt), 32'h2);

`ifdef ARB_LOCK_EN
    // Lock held by requester 1 for three cycles, then released
    step(1'b0, 4'b0001, $urandom(), 4'b0000);
    prev_wd = '0;
    for (int i = 0; i < 3; i++) begin
      wd = $urandom();
      step(1'b0, 4'b1111, wd, 4'b0010);
      check("lock_gnt", 32'(obs_gnt), 32'h2);
      if (i > 0) check("lock_q", 32'(obs_q), 32'(prev_wd[15:8]));
      prev_wd = wd;
    end
    step(1'b0, 4'b1111, $urandom(), 4'b0000);
    check("unlock_gnt", 32'(obs_gnt), 32'h4);
    check("unlock_q",   32'(obs_q),   32'(prev_wd[15:8]));
`endif

    // Reset while requester 3 owns the register
    step(1'b0, 4'b1000, $urandom(), 4'b1000);
    step(1'b0, 4'b1111, 32'hFFFFFFFF, 4'b1000);
    step(1'b1, 4'b1111, $urandom(), 4'b1000);
    check("midrst_q", 32'(obs_q), 32'd0);
    step(1'b1, 4'b1111, $urandom(), 4'b1000);
    step(1'b0, 4'b1111, $urandom(), 4'b0000);
    check("midrst_first", 32'(obs_gnt), 32'h1);

    // Randomized traffic
    for (int i = 0; i < 1500; i++) begin
      logic       r;
      logic [3:0] rq;
      logic [3:0] lk;
      r  = ($urandom_range(0, 49) == 0);
      rq = 4'($urandom());
      lk = 4'($urandom()) & 4'($urandom());
      step(r, rq, $urandom(), lk);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
